mem_arbiter: RTL and testbench

- Shares one memory_controller port between N_IDS CPU requesters (harts), with round-robin grant held for the full transaction.
- Sits between the per-hart data buses and memory_controller.
- Forwards the granted hart's full bus request (incl. atomic fields) and tags it with the hart id, so the LR/SC reservation table sees the correct requester.
- Routes ack and read data back only to the granted hart.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_rr_picker.sv | 28 ++
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - LR/SC funct5 codes and arbiter state encoding for mem_arbiter.
package mem_arbiter_pkg;

    localparam logic [4:0] FUNCT5_LR = 5'b00010;
    localparam logic [4:0] FUNCT5_SC = 5'b00011;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY    = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    function automatic logic is_funct5(input logic atomic, input logic [6:0] operation,
                                       input logic [4:0] code);
        return atomic && (operation[6:2] == code);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rtl/mem_arbiter_rr_picker.sv - combinational round-robin priority encoder, search from ptr upward with wrap.
module mem_arbiter_rr_picker #(
    parameter int N_IDS = 2,
    parameter int ID_W  = $clog2(N_IDS)
) (
    input  logic [N_IDS-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic             valid,
    output logic [ID_W-1:0]  index
);

    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int i = 0; i < N_IDS; i++) begin
            int j;
            j = int'(rr_ptr) + i;
            if (j >= N_IDS) begin
                j = j - N_IDS;
            end
            if (!valid && req[j]) begin
                valid = 1'b1;
                index = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory_controller port between N_IDS harts.
// Optional LR/SC lock (hart held exclusive between LR and SC) enabled by MEM_ARB_LRSC_LOCK_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int N_IDS        = 2,
    parameter int ID_W         = $clog2(N_IDS),
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_IDS-1:0]     i_req_bus_en,
    input  logic [N_IDS-1:0]     i_req_wr_en,
    input  logic [32*N_IDS-1:0]  i_req_wr_data,
    input  logic [32*N_IDS-1:0]  i_req_addr,
    input  logic [4*N_IDS-1:0]   i_req_byte_en,
    input  logic [N_IDS-1:0]     i_req_atomic,
    input  logic [7*N_IDS-1:0]   i_req_operation,
    output logic [N_IDS-1:0]     o_req_ack,
    output logic [32*N_IDS-1:0]  o_req_rd_data,
    output logic                 o_bus_en,
    output logic                 o_wr_en,
    output logic [31:0]          o_wr_data,
    output logic [31:0]          o_addr,
    output logic [3:0]           o_byte_en,
    output logic                 o_atomic,
    output logic [6:0]           o_operation,
    output logic [ID_W-1:0]      o_id,
    input  logic                 i_ack,
    input  logic [31:0]          i_rd_data
);

    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [N_IDS-1:0]  pick_req;
    logic              pick_valid;
    logic [ID_W-1:0]   pick_idx;
    logic              sel_bus_en;
    logic              sel_atomic;
    logic [6:0]        sel_operation;

    function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] g);
        return (int'(g) == N_IDS - 1) ? '0 : g + 1'b1;
    endfunction

    assign sel_bus_en    = i_req_bus_en[grant_q];
    assign sel_atomic    = i_req_atomic[grant_q];
    assign sel_operation = i_req_operation[7*int'(grant_q) +: 7];

`ifdef MEM_ARB_LRSC_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    logic              lock_q, lock_d;
    logic [ID_W-1:0]   lock_id_q, lock_id_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;

    // While locked only the LR owner is visible to the picker.
    assign pick_req = lock_q ? (i_req_bus_en & (N_IDS'(1) << lock_id_q)) : i_req_bus_en;
`else
    assign pick_req = i_req_bus_en;
`endif

    mem_arbiter_rr_picker #(
        .N_IDS (N_IDS),
        .ID_W  (ID_W)
    ) u_rr_picker (
        .req    (pick_req),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .index  (pick_idx)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef MEM_ARB_LRSC_LOCK_EN
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            lock_q     <= 1'b0;
            lock_id_q  <= '0;
            lock_cnt_q <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_id_q  <= lock_id_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end
`endif

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        o_req_ack     = '0;
        o_req_rd_data = '0;
        o_bus_en      = 1'b0;
        o_wr_en       = 1'b0;
        o_wr_data     = '0;
        o_addr        = '0;
        o_byte_en     = '0;
        o_atomic      = 1'b0;
        o_operation   = '0;
        o_id          = '0;

        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                // A hart dropping its request early keeps the grant; bus_en simply follows it.
                o_bus_en = sel_bus_en;
                if (sel_bus_en) begin
                    o_wr_en     = i_req_wr_en[grant_q];
                    o_wr_data   = i_req_wr_data[32*int'(grant_q) +: 32];
                    o_addr      = i_req_addr[32*int'(grant_q) +: 32];
                    o_byte_en   = i_req_byte_en[4*int'(grant_q) +: 4];
                    o_atomic    = sel_atomic;
                    o_operation = sel_operation;
                    o_id        = grant_q;
                end
                if (i_ack) begin
                    o_req_ack[grant_q]                      = 1'b1;
                    o_req_rd_data[32*int'(grant_q) +: 32]   = i_rd_data;
                    rr_ptr_d                                = ptr_inc(grant_q);
                    state_d                                 = ARB_RELEASE;
                end
            end
            ARB_RELEASE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

`ifdef MEM_ARB_LRSC_LOCK_EN
        lock_d     = lock_q;
        lock_id_d  = lock_id_q;
        lock_cnt_d = lock_cnt_q;
        if (state_q == ARB_BUSY && i_ack) begin
            if (lock_q) begin
                if (is_funct5(sel_atomic, sel_operation, FUNCT5_SC)) begin
                    lock_d = 1'b0;
                end else begin
                    lock_cnt_d = '0;
                    rr_ptr_d   = rr_ptr_q;
                end
            end else if (is_funct5(sel_atomic, sel_operation, FUNCT5_LR)) begin
                lock_d     = 1'b1;
                lock_id_d  = grant_q;
                lock_cnt_d = '0;
                rr_ptr_d   = rr_ptr_q;
            end
        end else if (lock_q && state_q != ARB_BUSY) begin
            if (i_req_bus_en[lock_id_q]) begin
                lock_cnt_d = '0;
            end else if (lock_cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                lock_d   = 1'b0;
                rr_ptr_d = ptr_inc(lock_id_q);
            end else begin
                lock_cnt_d = lock_cnt_q + 1'b1;
            end
        end
`endif
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

    localparam int N  = 2;
    localparam int IW = 1;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b0;
    logic [N-1:0]      req_bus_en;
    logic [N-1:0]      req_wr_en;
    logic [32*N-1:0]   req_wr_data;
    logic [32*N-1:0]   req_addr;
    logic [4*N-1:0]    req_byte_en;
    logic [N-1:0]      req_atomic;
    logic [7*N-1:0]    req_operation;
    logic [N-1:0]      o_req_ack;
    logic [32*N-1:0]   o_req_rd_data;
    logic              o_bus_en;
    logic              o_wr_en;
    logic [31:0]       o_wr_data;
    logic [31:0]       o_addr;
    logic [3:0]        o_byte_en;
    logic              o_atomic;
    logic [6:0]        o_operation;
    logic [IW-1:0]     o_id;
    logic              i_ack;
    logic [31:0]       i_rd_data;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_arbiter #(.N_IDS(N), .LOCK_TIMEOUT(16)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_req_bus_en    (req_bus_en),
        .i_req_wr_en     (req_wr_en),
        .i_req_wr_data   (req_wr_data),
        .i_req_addr      (req_addr),
        .i_req_byte_en   (req_byte_en),
        .i_req_atomic    (req_atomic),
        .i_req_operation (req_operation),
        .o_req_ack       (o_req_ack),
        .o_req_rd_data   (o_req_rd_data),
        .o_bus_en        (o_bus_en),
        .o_wr_en         (o_wr_en),
        .o_wr_data       (o_wr_data),
        .o_addr          (o_addr),
        .o_byte_en       (o_byte_en),
        .o_atomic        (o_atomic),
        .o_operation     (o_operation),
        .o_id            (o_id),
        .i_ack           (i_ack),
        .i_rd_data       (i_rd_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic clear_inputs();
        req_bus_en    = '0;
        req_wr_en     = '0;
        req_wr_data   = '0;
        req_addr      = '0;
        req_byte_en   = '0;
        req_atomic    = '0;
        req_operation = '0;
        i_ack         = 1'b0;
        i_rd_data     = '0;
    endtask

    task automatic step();
        @(negedge i_clk);
        #1;
    endtask

    // Memory side: waits (bounded) for o_bus_en, acks on BUSY cycle 'lat', then the acked hart drops its request.
    task automatic serve(input int lat, input logic [31:0] rdata, output int id,
                         output logic [N-1:0] ackv, output logic [31:0] lane, output bit timeout);
        int n;
        n = 0;
        timeout = 1'b0;
        while (!o_bus_en && n < 40) begin
            step();
            n++;
        end
        if (!o_bus_en) begin
            timeout = 1'b1;
            id = 0;
            ackv = '0;
            lane = '0;
            return;
        end
        id = int'(o_id);
        for (int k = 1; k < lat; k++) step();
        i_ack = 1'b1;
        i_rd_data = rdata;
        #1;
        ackv = o_req_ack;
        lane = o_req_rd_data[32*id +: 32];
        step();
        i_ack = 1'b0;
        i_rd_data = '0;
        req_bus_en[id] = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b0;
        step();
        step();
        i_rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        i_rst = 1'b0;
        req_bus_en = 2'b11;
        req_addr = 64'h0000_0300_0000_0200;
        i_ack = 1'b1;
        i_rd_data = 32'hCAFE_F00D;
        step();
        step();
        n_cmp++;
        if (o_bus_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_bus_en: got %b want 0", o_bus_en);
        end
        n_cmp++;
        if (o_req_ack !== 2'b00 || o_req_rd_data !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_ack: got ack %b data %h want 0/0", o_req_ack, o_req_rd_data);
        end
        n_cmp++;
        if ({o_wr_en, o_wr_data, o_addr, o_byte_en, o_atomic, o_operation, o_id} !== '0) begin
            n_fail++;
            $display("FAIL reset_fields: got addr %h id %h want 0", o_addr, o_id);
        end
        clear_inputs();
        i_rst = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        int cnt_ack;
        clear_inputs();
        req_bus_en[1] = 1'b1;
        req_addr[63:32] = 32'h0000_0100;
        #1;
        n_cmp++;
        if (o_bus_en !== 1'b0) begin
            n_fail++;
            $display("FAIL read_idle_bus_en: got %b want 0", o_bus_en);
        end
        step();
        n_cmp++;
        if (o_bus_en !== 1'b1 || o_id !== 1'b1 || o_addr !== 32'h100 || o_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL read_busy_fields: got en %b id %0d addr %h we %b want 1 1 00000100 0",
                     o_bus_en, o_id, o_addr, o_wr_en);
        end
        step();
        step();
        i_ack = 1'b1;
        i_rd_data = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if (o_req_ack !== 2'b10 || o_req_rd_data !== {32'hDEAD_BEEF, 32'h0}) begin
            n_fail++;
            $display("FAIL read_ack: got ack %b data %h want 10 deadbeef00000000", o_req_ack, o_req_rd_data);
        end
        step();
        i_ack = 1'b0;
        i_rd_data = '0;
        req_bus_en = '0;
        #1;
        cnt_ack = 0;
        n_cmp++;
        if (o_bus_en !== 1'b0 || o_req_ack !== 2'b00) begin
            n_fail++;
            $display("FAIL read_release: got en %b ack %b want 0 00", o_bus_en, o_req_ack);
        end
        step();
    endtask

    task automatic test_round_robin();
        int id;
        logic [N-1:0] ackv;
        logic [31:0] lane;
        bit to;
        int exp_order[4] = '{0, 1, 0, 1};
        clear_inputs();
        do_reset();
        req_bus_en = 2'b11;
        for (int t = 0; t < 4; t++) begin
            serve(2, 32'hA000_0000 + t, id, ackv, lane, to);
            n_cmp++;
            if (to || id !== exp_order[t] || lane !== 32'hA000_0000 + t) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got id %0d data %h timeout %0d want id %0d data %h",
                         t, id, lane, to, exp_order[t], 32'hA000_0000 + t);
            end
            req_bus_en[id] = 1'b1;
        end
        clear_inputs();
        step();
        step();
    endtask

    task automatic test_grant_hold();
        int id;
        int bad;
        logic [N-1:0] ackv;
        logic [31:0] lane;
        bit to;
        clear_inputs();
        do_reset();
        req_bus_en[0] = 1'b1;
        req_wr_en[0] = 1'b1;
        req_wr_data[31:0] = 32'h1234_5678;
        req_addr[31:0] = 32'h0000_0200;
        req_byte_en[3:0] = 4'b0011;
        step();
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                req_bus_en[1] = 1'b1;
                req_addr[63:32] = 32'h0000_0400;
                #1;
            end
            if (o_bus_en !== 1'b1 || o_id !== 1'b0 || o_wr_en !== 1'b1 ||
                o_wr_data !== 32'h1234_5678 || o_byte_en !== 4'b0011 || o_addr !== 32'h200) bad++;
            step();
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL hold_grant: got %0d bad cycles want 0", bad);
        end
        i_ack = 1'b1;
        #1;
        n_cmp++;
        if (o_req_ack !== 2'b01 || o_id !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_ack: got ack %b id %0d want 01 0", o_req_ack, o_id);
        end
        step();
        i_ack = 1'b0;
        req_bus_en[0] = 1'b0;
        #1;
        serve(1, 32'h5555_AAAA, id, ackv, lane, to);
        n_cmp++;
        if (to || id !== 1 || ackv !== 2'b10) begin
            n_fail++;
            $display("FAIL hold_next: got id %0d ack %b timeout %0d want 1 10", id, ackv, to);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_async_reset();
        int id;
        logic [N-1:0] ackv;
        logic [31:0] lane;
        bit to;
        clear_inputs();
        do_reset();
        req_bus_en[1] = 1'b1;
        req_addr[63:32] = 32'h0000_0800;
        step();
        step();
        i_ack = 1'b1;
        i_rd_data = 32'h0BAD_0BAD;
        #1;
        i_rst = 1'b0;
        #1;
        n_cmp++;
        if (o_bus_en !== 1'b0 || o_addr !== 32'h0 || o_id !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_fields: got en %b addr %h id %0d want 0 0 0", o_bus_en, o_addr, o_id);
        end
        n_cmp++;
        if (o_req_ack !== 2'b00 || o_req_rd_data !== 64'h0) begin
            n_fail++;
            $display("FAIL areset_ack: got ack %b data %h want 00 0", o_req_ack, o_req_rd_data);
        end
        step();
        i_ack = 1'b0;
        i_rd_data = '0;
        i_rst = 1'b1;
        req_bus_en = 2'b11;
        #1;
        serve(1, 32'h1111_2222, id, ackv, lane, to);
        n_cmp++;
        if (to || id !== 0 || ackv !== 2'b01) begin
            n_fail++;
            $display("FAIL areset_regrant: got id %0d ack %b timeout %0d want 0 01", id, ackv, to);
        end
        clear_inputs();
        step();
        step();
    endtask

    task automatic test_amo();
        int bad;
        int acks;
        clear_inputs();
        do_reset();
        req_bus_en[0] = 1'b1;
        req_atomic[0] = 1'b1;
        req_operation[6:0] = 7'b0000011;
        req_addr[31:0] = 32'h0000_0040;
        req_wr_data[31:0] = 32'h0000_0005;
        step();
        bad = 0;
        acks = 0;
        for (int c = 0; c < 4; c++) begin
            if (o_bus_en !== 1'b1 || o_atomic !== 1'b1 || o_operation !== 7'b0000011 ||
                o_wr_data !== 32'h5) bad++;
            acks += int'(o_req_ack[0]) + int'(o_req_ack[1]);
            if (c == 3) begin
                i_ack = 1'b1;
                i_rd_data = 32'h0000_0009;
                #1;
                acks += int'(o_req_ack[0]) + int'(o_req_ack[1]);
            end
            step();
        end
        i_ack = 1'b0;
        req_bus_en = '0;
        #1;
        for (int c = 0; c < 3; c++) begin
            acks += int'(o_req_ack[0]) + int'(o_req_ack[1]);
            step();
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL amo_stable: got %0d bad cycles want 0", bad);
        end
        n_cmp++;
        if (acks !== 1) begin
            n_fail++;
            $display("FAIL amo_ack_count: got %0d ack pulses want 1", acks);
        end
        clear_inputs();
    endtask

`ifdef MEM_ARB_LRSC_LOCK_EN
    task automatic test_lrsc_lock();
        int id;
        int n;
        logic [N-1:0] ackv;
        logic [31:0] lane;
        bit to;
        clear_inputs();
        do_reset();
        req_bus_en[0] = 1'b1;
        req_atomic[0] = 1'b1;
        req_operation[6:0] = {5'b00010, 2'b00};
        serve(1, 32'h0, id, ackv, lane, to);
        req_bus_en[1] = 1'b1;
        for (int c = 0; c < 6; c++) step();
        n_cmp++;
        if (o_bus_en !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_block: got en %b want 0", o_bus_en);
        end
        req_bus_en[0] = 1'b1;
        req_operation[6:0] = {5'b00011, 2'b00};
        serve(1, 32'h0, id, ackv, lane, to);
        n_cmp++;
        if (to || id !== 0) begin
            n_fail++;
            $display("FAIL lock_sc_first: got id %0d timeout %0d want 0", id, to);
        end
        serve(1, 32'h0, id, ackv, lane, to);
        n_cmp++;
        if (to || id !== 1) begin
            n_fail++;
            $display("FAIL lock_after_sc: got id %0d timeout %0d want 1", id, to);
        end
        clear_inputs();
        step();
        step();
        req_bus_en[0] = 1'b1;
        req_atomic[0] = 1'b1;
        req_operation[6:0] = {5'b00010, 2'b00};
        serve(1, 32'h0, id, ackv, lane, to);
        req_bus_en[1] = 1'b1;
        n = 0;
        while (!o_bus_en && n < 40) begin
            step();
            n++;
        end
        n_cmp++;
        if (o_id !== 1'b1 || n < 16 || n > 18) begin
            n_fail++;
            $display("FAIL lock_timeout: got id %0d after %0d cycles want 1 after 16..18", o_id, n);
        end
        i_ack = 1'b1;
        step();
        clear_inputs();
        step();
    endtask
`endif

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_grant_hold();
        test_async_reset();
        test_amo();
`ifdef MEM_ARB_LRSC_LOCK_EN
        test_lrsc_lock();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
